// File: rtl/sccb_target_pkg.sv
// Shared SCCB definitions: FSM state encoding, device IDs and ACK/NA bit values.
package sccb_target_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ID,
      ST_ID_ACK,
      ST_SUB,
      ST_SUB_ACK,
      ST_WDAT,
      ST_WDAT_ACK,
      ST_RDAT,
      ST_RDAT_ACK
   } state_t;

   localparam logic [7:0] SCCB_WR_ID = 8'h60;
   localparam logic [7:0] SCCB_RD_ID = 8'h61;
   localparam logic       BIT_ACK    = 1'b0;
   localparam logic       BIT_NA     = 1'b1;

   // Bit 0 of the ID byte is the R/W flag, so only [7:1] identifies the device.
   function automatic logic id_match(input logic [7:0] id_byte, input logic [7:0] dev_id);
      return id_byte[7:1] == dev_id[7:1];
   endfunction

endpackage

// File: rtl/sccb_target_if.sv
// SCCB pad lines plus the byte register-file port of the SCCB responder.
interface sccb_target_if;
   logic       i_scl;
   logic       i_sda;
   logic       o_sda_oe;
   logic       o_wr_en;
   logic [7:0] o_wr_addr;
   logic [7:0] o_wr_data;
   logic [7:0] o_rd_addr;
   logic [7:0] i_rd_data;
   logic       o_busy;

   modport slave (
      input  i_scl, i_sda, i_rd_data,
      output o_sda_oe, o_wr_en, o_wr_addr, o_wr_data, o_rd_addr, o_busy
   );

   modport master (
      output i_scl, i_sda, i_rd_data,
      input  o_sda_oe, o_wr_en, o_wr_addr, o_wr_data, o_rd_addr, o_busy
   );
endinterface

// File: rtl/sccb_target_line_filter.sv
// Two-flop synchronizer, FILT_LEN-sample glitch filter and rise/fall strobes for one bus line.
module sccb_target_line_filter #(
   parameter int FILT_LEN = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic i_line,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic [1:0] r_sync;
   logic       r_level;
   logic [2:0] r_cnt;
   logic       r_rise;
   logic       r_fall;

   // Idle bus level is high, so everything resets to 1 and no edge fires out of reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync  <= 2'b11;
         r_level <= 1'b1;
         r_cnt   <= '0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_sync <= {r_sync[0], i_line};
         r_rise <= 1'b0;
         r_fall <= 1'b0;
         if (r_sync[1] == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == 3'(FILT_LEN - 1)) begin
            r_cnt   <= '0;
            r_level <= r_sync[1];
            r_rise  <= r_sync[1];
            r_fall  <= ~r_sync[1];
         end else begin
            r_cnt <= r_cnt + 3'd1;
         end
      end
   end

   assign o_level = r_level;
   assign o_rise  = r_rise;
   assign o_fall  = r_fall;

endmodule

// File: rtl/sccb_target.sv
// SCCB responder (OV2640 control-port model): 3-phase writes, 2-phase reads, byte reg-file port.
// Define SCCB_TGT_ACK_EN to pull sda low in the slave ACK slots; otherwise they are left released.
module sccb_target
   import sccb_target_pkg::*;
#(
   parameter logic [7:0] DEV_ID   = SCCB_WR_ID,
   parameter int         FILT_LEN = 3
) (
   input  logic         clk,
   input  logic         reset,
   sccb_target_if.slave bus
);

`ifdef SCCB_TGT_ACK_EN
   localparam logic ACK_DRV = 1'b1;
`else
   localparam logic ACK_DRV = 1'b0;
`endif

   logic w_scl_lvl, w_scl_rise, w_scl_fall;
   logic w_sda_lvl, w_sda_rise, w_sda_fall;
   logic w_start, w_stop;
   logic [7:0] w_byte;

   state_t     r_state;
   logic [3:0] r_bit;
   logic [7:0] r_shift;
   logic [7:0] r_ptr;
   logic       r_rd;
   logic       r_na;
   logic       r_ack_seen;
   logic       r_sda_oe;
   logic       r_wr_en;
   logic [7:0] r_wr_addr;
   logic [7:0] r_wr_data;
   logic       r_busy;

   sccb_target_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
      .clk(clk), .reset(reset), .i_line(bus.i_scl),
      .o_level(w_scl_lvl), .o_rise(w_scl_rise), .o_fall(w_scl_fall)
   );

   sccb_target_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
      .clk(clk), .reset(reset), .i_line(bus.i_sda),
      .o_level(w_sda_lvl), .o_rise(w_sda_rise), .o_fall(w_sda_fall)
   );

   assign w_start = w_sda_fall & w_scl_lvl;
   assign w_stop  = w_sda_rise & w_scl_lvl;
   assign w_byte  = {r_shift[6:0], w_sda_lvl};

   // ACK slots: the first scl fall drives the slave ACK, the fall after the 9th rise leaves the slot.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_bit      <= '0;
         r_shift    <= '0;
         r_ptr      <= '0;
         r_rd       <= 1'b0;
         r_na       <= 1'b0;
         r_ack_seen <= 1'b0;
         r_sda_oe   <= 1'b0;
         r_wr_en    <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
         r_busy     <= 1'b0;
      end else begin
         r_wr_en <= 1'b0;
         if (w_stop) begin
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
            r_sda_oe <= 1'b0;
         end else if (w_start) begin
            r_state  <= ST_ID;
            r_bit    <= '0;
            r_busy   <= 1'b1;
            r_sda_oe <= 1'b0;
         end else if (w_scl_rise) begin
            case (r_state)
               ST_ID, ST_SUB, ST_WDAT: begin
                  r_shift <= w_byte;
                  r_bit   <= r_bit + 4'd1;
                  if (r_bit == 4'd7) begin
                     r_bit      <= '0;
                     r_ack_seen <= 1'b0;
                     case (r_state)
                        ST_ID: begin
                           if (id_match(w_byte, DEV_ID)) begin
                              r_rd    <= (w_byte[0] == SCCB_RD_ID[0]);
                              r_state <= ST_ID_ACK;
                           end else begin
                              r_state <= ST_IDLE;
                           end
                        end
                        ST_SUB: begin
                           r_ptr   <= w_byte;
                           r_state <= ST_SUB_ACK;
                        end
                        default: begin
                           r_wr_en   <= 1'b1;
                           r_wr_addr <= r_ptr;
                           r_wr_data <= w_byte;
                           r_ptr     <= r_ptr + 8'd1;
                           r_state   <= ST_WDAT_ACK;
                        end
                     endcase
                  end
               end
               ST_ID_ACK, ST_SUB_ACK, ST_WDAT_ACK: r_ack_seen <= 1'b1;
               ST_RDAT: r_bit <= r_bit + 4'd1;
               ST_RDAT_ACK: begin
                  r_ack_seen <= 1'b1;
                  r_na       <= w_sda_lvl;
                  if (w_sda_lvl == BIT_ACK) r_ptr <= r_ptr + 8'd1;
               end
               default: ;
            endcase
         end else if (w_scl_fall) begin
            case (r_state)
               ST_ID_ACK, ST_SUB_ACK, ST_WDAT_ACK: begin
                  if (!r_ack_seen) begin
                     r_sda_oe <= ACK_DRV;
                  end else begin
                     r_sda_oe <= 1'b0;
                     if (r_state == ST_ID_ACK && r_rd) begin
                        r_shift  <= bus.i_rd_data;
                        r_sda_oe <= ~bus.i_rd_data[7];
                        r_bit    <= '0;
                        r_state  <= ST_RDAT;
                     end else if (r_state == ST_ID_ACK) begin
                        r_state <= ST_SUB;
                     end else begin
                        r_state <= ST_WDAT;
                     end
                  end
               end
               ST_RDAT: begin
                  if (r_bit == 4'd8) begin
                     r_sda_oe   <= 1'b0;
                     r_bit      <= '0;
                     r_ack_seen <= 1'b0;
                     r_state    <= ST_RDAT_ACK;
                  end else begin
                     r_sda_oe <= ~r_shift[6];
                     r_shift  <= {r_shift[6:0], 1'b0};
                  end
               end
               ST_RDAT_ACK: begin
                  if (r_ack_seen) begin
                     if (r_na == BIT_NA) begin
                        r_state <= ST_IDLE;
                     end else begin
                        r_shift  <= bus.i_rd_data;
                        r_sda_oe <= ~bus.i_rd_data[7];
                        r_state  <= ST_RDAT;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.o_sda_oe  = r_sda_oe;
   assign bus.o_wr_en   = r_wr_en;
   assign bus.o_wr_addr = r_wr_addr;
   assign bus.o_wr_data = r_wr_data;
   assign bus.o_rd_addr = r_ptr;
   assign bus.o_busy    = r_busy;

endmodule

// File: tb/tb_sccb_target.sv
// Bench for sccb_target: bit-banged SCCB initiator, register-file model and expected-write queue.
module tb_sccb_target;

   localparam int Q = 100;
`ifdef SCCB_TGT_ACK_EN
   localparam logic EXP_ACK = 1'b0;
`else
   localparam logic EXP_ACK = 1'b1;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic m_scl = 1'b1;
   logic m_sda = 1'b1;
   logic env_load = 1'b0;
   logic g_glitch = 1'b0;

   sccb_target_if bus ();

   sccb_target dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [7:0]  env_regs [256];
   logic [7:0]  m_regs   [256];
   logic [7:0]  m_ptr;
   logic [15:0] wq [$];
   logic [15:0] eq [$];
   int          w_rd = 0;
   int          oe_cycles = 0;
   int          n_vec = 0;
   int          n_err = 0;

   assign bus.i_scl     = m_scl;
   assign bus.i_sda     = m_sda & ~bus.o_sda_oe;
   assign bus.i_rd_data = env_regs[bus.o_rd_addr];

   always @(negedge clk) begin
      if (env_load) begin
         for (int i = 0; i < 256; i++) env_regs[i] = m_regs[i];
      end else if (bus.o_wr_en) begin
         wq.push_back({bus.o_wr_addr, bus.o_wr_data});
         env_regs[bus.o_wr_addr] = bus.o_wr_data;
      end
      if (bus.o_sda_oe) oe_cycles = oe_cycles + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start_c();
      m_sda = 1'b1; #Q; m_scl = 1'b1; #Q; m_sda = 1'b0; #Q; m_scl = 1'b0; #Q;
   endtask

   task automatic stop_c();
      m_sda = 1'b0; #Q; m_scl = 1'b1; #Q; m_sda = 1'b1; #(2*Q);
   endtask

   task automatic bit_out(input logic b);
      m_sda = b; #Q; m_scl = 1'b1;
      if (g_glitch) begin
         #(Q-20); m_sda = ~b; #10; m_sda = b; #(Q+10);
      end else begin
         #(2*Q);
      end
      m_scl = 1'b0; #Q;
   endtask

   task automatic bit_in(output logic b, output logic oe);
      m_sda = 1'b1; #Q; m_scl = 1'b1; #Q;
      b = bus.i_sda; oe = bus.o_sda_oe;
      #Q; m_scl = 1'b0; #Q;
   endtask

   task automatic wr_byte(input logic [7:0] v, output logic ack);
      logic oe;
      for (int i = 7; i >= 0; i--) bit_out(v[i]);
      bit_in(ack, oe);
   endtask

   task automatic rd_byte(output logic [7:0] v, input logic na, output logic oe9);
      logic b, oe;
      for (int i = 7; i >= 0; i--) begin
         bit_in(b, oe);
         v[i] = b;
      end
      m_sda = na; #Q; m_scl = 1'b1; #Q; oe9 = bus.o_sda_oe; #Q; m_scl = 1'b0; #Q;
   endtask

   task automatic check_writes(input string tag);
      chk({tag, " wr_count"}, 32'(wq.size() - w_rd), 32'(eq.size()));
      for (int i = 0; i < eq.size(); i++)
         if (w_rd + i < wq.size()) chk({tag, " wr_addr_data"}, 32'(wq[w_rd + i]), 32'(eq[i]));
      w_rd = wq.size();
      eq.delete();
   endtask

   task automatic write_tx(input logic [7:0] id, input logic [7:0] sub,
                           input logic [7:0] d [4], input int n, input string tag);
      logic       a, exp_a, match;
      logic [7:0] dev;
      int         oe0;
      dev   = 8'h60;
      match = (id[7:1] == dev[7:1]);
      exp_a = match ? EXP_ACK : 1'b1;
      oe0   = oe_cycles;
      start_c();
      chk({tag, " busy_start"}, 32'(bus.o_busy), 32'd1);
      wr_byte(id, a);
      chk({tag, " id_ack"}, 32'(a), 32'(exp_a));
      wr_byte(sub, a);
      chk({tag, " sub_ack"}, 32'(a), 32'(exp_a));
      for (int i = 0; i < n; i++) begin
         wr_byte(d[i], a);
         chk({tag, " dat_ack"}, 32'(a), 32'(exp_a));
      end
      stop_c();
      chk({tag, " busy_stop"}, 32'(bus.o_busy), 32'd0);
      if (!match) chk({tag, " no_drive"}, 32'(oe_cycles - oe0), 32'd0);
      if (match) begin
         m_ptr = sub;
         for (int i = 0; i < n; i++) begin
            eq.push_back({m_ptr, d[i]});
            m_regs[m_ptr] = d[i];
            m_ptr = m_ptr + 8'd1;
         end
      end
      check_writes(tag);
   endtask

   task automatic read_tx(input int k, input logic set_ptr, input logic [7:0] sub, input string tag);
      logic       a, oe9;
      logic [7:0] v;
      logic [7:0] none [4];
      none = '{default: 8'h00};
      if (set_ptr) write_tx(8'h60, sub, none, 0, {tag, " ptr"});
      start_c();
      wr_byte(8'h61, a);
      chk({tag, " rd_id_ack"}, 32'(a), 32'(EXP_ACK));
      for (int i = 0; i < k; i++) begin
         rd_byte(v, (i == k - 1), oe9);
         chk({tag, " rd_data"}, 32'(v), 32'(m_regs[m_ptr]));
         chk({tag, " rd_ack_released"}, 32'(oe9), 32'd0);
         if (i != k - 1) m_ptr = m_ptr + 8'd1;
      end
      stop_c();
      chk({tag, " busy_stop"}, 32'(bus.o_busy), 32'd0);
   endtask

   initial begin
      logic [7:0] d [4];
      logic       a, b, oe;
      for (int i = 0; i < 256; i++) m_regs[i] = 8'($urandom);
      m_regs[8'h0A] = 8'h26;
      m_ptr = 8'h00;
      env_load = 1'b1;
      #31;
      chk("reset sda_oe", 32'(bus.o_sda_oe), 32'd0);
      chk("reset wr_en", 32'(bus.o_wr_en), 32'd0);
      chk("reset wr_addr", 32'(bus.o_wr_addr), 32'd0);
      chk("reset wr_data", 32'(bus.o_wr_data), 32'd0);
      chk("reset rd_addr", 32'(bus.o_rd_addr), 32'd0);
      chk("reset busy", 32'(bus.o_busy), 32'd0);
      env_load = 1'b0;
      #19; reset = 1'b0; #(4*Q);

      d = '{8'h80, 8'h00, 8'h00, 8'h00};
      write_tx(8'h60, 8'h12, d, 1, "t1_write");

      read_tx(1, 1'b1, 8'h0A, "t2_read");

      // Reset while the target is pulling sda during a read bit.
      start_c();
      wr_byte(8'h61, a);
      m_sda = 1'b1; #Q; m_scl = 1'b1; #Q;
      chk("rst_mid oe_before", 32'(bus.o_sda_oe), 32'd1);
      reset = 1'b1; #1;
      chk("rst_mid oe_after", 32'(bus.o_sda_oe), 32'd0);
      chk("rst_mid busy", 32'(bus.o_busy), 32'd0);
      chk("rst_mid rd_addr", 32'(bus.o_rd_addr), 32'd0);
      #29; reset = 1'b0; #Q;
      m_scl = 1'b0; #Q;
      stop_c();
      m_ptr = 8'h00;

      d = '{8'h80, 8'h00, 8'h00, 8'h00};
      write_tx(8'h42, 8'h12, d, 1, "t3_wrong_id");
      d = '{8'h00, 8'h00, 8'h00, 8'h00};
      write_tx(8'h60, 8'h05, d, 1, "t3_next_write");

      d = '{8'hAA, 8'hBB, 8'h00, 8'h00};
      write_tx(8'h60, 8'hFF, d, 2, "t4_wrap");
      read_tx(2, 1'b1, 8'hFF, "t4_readback");

      start_c();
      wr_byte(8'h60, a);
      wr_byte(8'h12, a);
      for (int i = 7; i >= 4; i--) bit_out(i[0]);
      stop_c();
      chk("t5_partial busy", 32'(bus.o_busy), 32'd0);
      check_writes("t5_partial");

      m_sda = 1'b0; #10; m_sda = 1'b1; #(4*Q);
      chk("t5_idle_glitch busy", 32'(bus.o_busy), 32'd0);
      g_glitch = 1'b1;
      d = '{8'h5A, 8'hC3, 8'h00, 8'h00};
      write_tx(8'h60, 8'h33, d, 2, "t5_glitch_write");
      g_glitch = 1'b0;

      for (int it = 0; it < 12; it++) begin
         int         op, n;
         logic [7:0] id, sub;
         op  = $urandom_range(0, 3);
         n   = $urandom_range(1, 3);
         sub = 8'($urandom);
         for (int j = 0; j < 4; j++) d[j] = 8'($urandom);
         case (op)
            0: write_tx(8'h60, sub, d, n, "rnd_write");
            1: read_tx(n, 1'b1, sub, "rnd_read_set");
            2: read_tx(n, 1'b0, 8'h00, "rnd_read_cur");
            default: begin
               id = 8'($urandom);
               if (id[7:1] == 7'h30) id = id ^ 8'h80;
               write_tx(id, sub, d, n, "rnd_wrong_id");
            end
         endcase
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
